// File: rtl/puf_defs.sv
// Shared definitions for the PUF majority sampler: FSM encoding and default widths.
package puf_defs;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRIG   = 3'd1,
    WAIT   = 3'd2,
    GAP    = 3'd3,
    RESULT = 3'd4
  } state_e;

  localparam int DEF_CHALLENGE_WIDTH  = 64;
  localparam int DEF_PDL_CONFIG_WIDTH = 64;
  localparam int DEF_RESPONSE_WIDTH   = 6;
  localparam int DEF_EVAL_CNT_WIDTH   = 8;
  localparam int DEF_TIMEOUT_CYCLES   = 64;
  localparam int DEF_GAP_CYCLES       = 2;
endpackage

// File: rtl/puf_vote_counter.sv
// One response bit's ones-counter with majority and instability decode.
module puf_vote_counter
  import puf_defs::*;
#(
  parameter int W = DEF_EVAL_CNT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc_en,
  input  logic         bit_in,
  input  logic [W-1:0] n,
  output logic [W-1:0] ones,
  output logic         majority,
  output logic         unstable
);
  logic [W-1:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (clr)                  ones_d = '0;
    else if (inc_en && bit_in) ones_d = ones_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ones_q <= '0;
    else       ones_q <= ones_d;
  end

  assign ones = ones_q;

  // Decode the post-increment count so the final vote can be captured
  // in the same cycle as the last puf_done.
  assign majority = {ones_d, 1'b0} > {1'b0, n};
  assign unstable = (ones_d != '0) && (ones_d != n);
endmodule

// File: rtl/puf_majority_sampler.sv
// Fires the PUF N times per command and returns a majority-voted response,
// a per-bit instability mask and a watchdog timeout flag.
module puf_majority_sampler
  import puf_defs::*;
#(
  parameter int CHALLENGE_WIDTH  = DEF_CHALLENGE_WIDTH,
  parameter int PDL_CONFIG_WIDTH = DEF_PDL_CONFIG_WIDTH,
  parameter int RESPONSE_WIDTH   = DEF_RESPONSE_WIDTH,
  parameter int EVAL_CNT_WIDTH   = DEF_EVAL_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES       = DEF_GAP_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [CHALLENGE_WIDTH-1:0]  cmd_challenge,
  input  logic [PDL_CONFIG_WIDTH-1:0] cmd_pdl_config,
  input  logic [EVAL_CNT_WIDTH-1:0]   cmd_num_evals,
  output logic                        puf_trigger,
  output logic [CHALLENGE_WIDTH-1:0]  puf_challenge,
  output logic [PDL_CONFIG_WIDTH-1:0] puf_pdl_config,
  input  logic                        puf_done,
  input  logic [RESPONSE_WIDTH-1:0]   puf_raw_response,
  input  logic                        puf_xor_response,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [RESPONSE_WIDTH-1:0]   res_response,
  output logic                        res_xor,
  output logic [RESPONSE_WIDTH:0]     res_unstable,
  output logic                        res_timeout
);
  localparam int NB    = RESPONSE_WIDTH + 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_e                      state_q, state_d;
  logic [CHALLENGE_WIDTH-1:0]  chal_q, chal_d;
  logic [PDL_CONFIG_WIDTH-1:0] pdl_q, pdl_d;
  logic [EVAL_CNT_WIDTH-1:0]   n_q, n_d;
  logic [EVAL_CNT_WIDTH-1:0]   eval_cnt_q, eval_cnt_d;
  logic [WD_W-1:0]             wdog_q, wdog_d;
  logic [GAP_W-1:0]            gap_q, gap_d;
  logic [RESPONSE_WIDTH-1:0]   resp_q, resp_d;
  logic                        xor_q, xor_d;
  logic [NB-1:0]               unst_q, unst_d;
  logic                        to_q, to_d;

  logic                        vote_clr, vote_inc;
  logic [NB-1:0]               vote_bits, vote_maj, vote_unst;
  // Per-bit counts are visible for debug but the vote uses the decoded flags.
  logic [NB-1:0][EVAL_CNT_WIDTH-1:0] vote_ones_unused;

  assign vote_bits = {puf_xor_response, puf_raw_response};

  for (genvar b = 0; b < NB; b++) begin : g_vote
    puf_vote_counter #(.W(EVAL_CNT_WIDTH)) u_vote (
      .clk      (clk),
      .reset    (reset),
      .clr      (vote_clr),
      .inc_en   (vote_inc),
      .bit_in   (vote_bits[b]),
      .n        (n_q),
      .ones     (vote_ones_unused[b]),
      .majority (vote_maj[b]),
      .unstable (vote_unst[b])
    );
  end

  always_comb begin
    state_d    = state_q;
    chal_d     = chal_q;
    pdl_d      = pdl_q;
    n_d        = n_q;
    eval_cnt_d = eval_cnt_q;
    wdog_d     = wdog_q;
    gap_d      = gap_q;
    resp_d     = resp_q;
    xor_d      = xor_q;
    unst_d     = unst_q;
    to_d       = to_q;
    vote_clr   = 1'b0;
    vote_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          chal_d     = cmd_challenge;
          pdl_d      = cmd_pdl_config;
          n_d        = (cmd_num_evals == '0) ? EVAL_CNT_WIDTH'(1) : cmd_num_evals;
          eval_cnt_d = '0;
          to_d       = 1'b0;
          vote_clr   = 1'b1;
          state_d    = TRIG;
        end
      end
      TRIG: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // A done landing on the last watchdog cycle still counts.
        if (puf_done) begin
          vote_inc   = 1'b1;
          eval_cnt_d = eval_cnt_q + 1'b1;
          gap_d      = '0;
          if (eval_cnt_q + 1'b1 == n_q) begin
            resp_d  = vote_maj[RESPONSE_WIDTH-1:0];
            xor_d   = vote_maj[RESPONSE_WIDTH];
            unst_d  = vote_unst;
            state_d = RESULT;
          end else begin
            state_d = GAP;
          end
        end else if (wdog_q == WD_LAST) begin
          resp_d  = '0;
          xor_d   = 1'b0;
          unst_d  = '1;
          to_d    = 1'b1;
          state_d = RESULT;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = TRIG;
        else                   gap_d   = gap_q + 1'b1;
      end
      RESULT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      chal_q     <= '0;
      pdl_q      <= '0;
      n_q        <= '0;
      eval_cnt_q <= '0;
      wdog_q     <= '0;
      gap_q      <= '0;
      resp_q     <= '0;
      xor_q      <= 1'b0;
      unst_q     <= '0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      chal_q     <= chal_d;
      pdl_q      <= pdl_d;
      n_q        <= n_d;
      eval_cnt_q <= eval_cnt_d;
      wdog_q     <= wdog_d;
      gap_q      <= gap_d;
      resp_q     <= resp_d;
      xor_q      <= xor_d;
      unst_q     <= unst_d;
      to_q       <= to_d;
    end
  end

  assign cmd_ready      = (state_q == IDLE);
  assign puf_trigger    = (state_q == TRIG);
  assign res_valid      = (state_q == RESULT);
  assign puf_challenge  = chal_q;
  assign puf_pdl_config = pdl_q;
  assign res_response   = resp_q;
  assign res_xor        = xor_q;
  assign res_unstable   = unst_q;
  assign res_timeout    = to_q;
endmodule

// File: tb/tb_puf_majority_sampler.sv
// Table-driven bench with a PUF response model and a result scoreboard.
module tb_puf_majority_sampler;
  localparam int CW = 64, PW = 64, RW = 6, EW = 8, TO = 64, GAP = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [CW-1:0] cmd_challenge;
  logic [PW-1:0] cmd_pdl_config;
  logic [EW-1:0] cmd_num_evals;
  logic          puf_trigger;
  logic [CW-1:0] puf_challenge;
  logic [PW-1:0] puf_pdl_config;
  logic          puf_done;
  logic [RW-1:0] puf_raw_response;
  logic          puf_xor_response;
  logic          res_valid, res_ready;
  logic [RW-1:0] res_response;
  logic          res_xor;
  logic [RW:0]   res_unstable;
  logic          res_timeout;

  puf_majority_sampler #(
    .CHALLENGE_WIDTH(CW), .PDL_CONFIG_WIDTH(PW), .RESPONSE_WIDTH(RW),
    .EVAL_CNT_WIDTH(EW), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_challenge(cmd_challenge), .cmd_pdl_config(cmd_pdl_config),
    .cmd_num_evals(cmd_num_evals),
    .puf_trigger(puf_trigger), .puf_challenge(puf_challenge),
    .puf_pdl_config(puf_pdl_config), .puf_done(puf_done),
    .puf_raw_response(puf_raw_response), .puf_xor_response(puf_xor_response),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_response(res_response), .res_xor(res_xor),
    .res_unstable(res_unstable), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // PUF model: answers each trigger after m_lat cycles unless m_hang.
  logic [4:0][RW-1:0] m_raw;
  logic [4:0]         m_xor;
  int                 m_lat  = 1;
  bit                 m_hang = 1'b0;
  int                 m_idx  = 0;
  int                 trig_q[$];
  int                 done_q[$];

  initial begin
    puf_done = 1'b0;
    puf_raw_response = '0;
    puf_xor_response = 1'b0;
    forever begin
      tick();
      if (puf_trigger === 1'b1) begin
        trig_q.push_back(cyc);
        if (!m_hang) begin
          repeat (m_lat) @(posedge clk);
          #1;
          puf_done = 1'b1;
          puf_raw_response = m_raw[(m_idx < 5) ? m_idx : 4];
          puf_xor_response = m_xor[(m_idx < 5) ? m_idx : 4];
          done_q.push_back(cyc);
          m_idx++;
          tick();
          puf_done = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [RW-1:0] resp;
    logic          xr;
    logic [RW:0]   unst;
    logic          to;
    logic [CW-1:0] chal;
    logic [PW-1:0] pdl;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [EW-1:0]      n;
    logic [4:0][RW-1:0] raw;
    logic [4:0]         xr;
    int                 lat;
    bit                 hang;
    logic [RW-1:0]      e_resp;
    logic               e_xor;
    logic [RW:0]        e_unst;
    logic               e_to;
    int                 e_trig;
  } vec_t;

  function automatic vec_t mk(logic [EW-1:0] n, logic [29:0] raw, logic [4:0] xr, int lat,
                              bit hang, logic [RW-1:0] er, logic ex, logic [RW:0] eu,
                              logic et, int tr);
    vec_t v;
    v.n = n; v.raw = raw; v.xr = xr; v.lat = lat; v.hang = hang;
    v.e_resp = er; v.e_xor = ex; v.e_unst = eu; v.e_to = et; v.e_trig = tr;
    return v;
  endfunction

  task automatic send(input logic [EW-1:0] n, input logic [CW-1:0] c, input logic [PW-1:0] p,
                      output int acc);
    int k = 0;
    cmd_num_evals = n; cmd_challenge = c; cmd_pdl_config = p; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && k < 200) begin tick(); k++; end
    chk("cmd_accept_seen", 64'(cmd_ready), 64'(1'b1));
    acc = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int rv);
    int k = 0;
    while (res_valid !== 1'b1 && k < 1000) begin tick(); k++; end
    chk("res_valid_seen", 64'(res_valid), 64'(1'b1));
    rv = cyc;
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_sb: result with empty scoreboard", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_resp"}, 64'(res_response), 64'(e.resp));
    chk({tag, "_xor"}, 64'(res_xor), 64'(e.xr));
    chk({tag, "_unst"}, 64'(res_unstable), 64'(e.unst));
    chk({tag, "_timeout"}, 64'(res_timeout), 64'(e.to));
    chk({tag, "_chal_held"}, puf_challenge, e.chal);
    chk({tag, "_pdl_held"}, puf_pdl_config, e.pdl);
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_ready_after_hs"}, 64'(cmd_ready), 64'(1'b1));
  endtask

  vec_t vt[10];

  initial begin
    int acc, rv;
    exp_t e;
    logic [CW-1:0] c2;
    logic [RW-1:0] s_resp;
    logic [RW:0]   s_unst;
    logic          s_xor;
    bit            bad;

    reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_challenge = '0; cmd_pdl_config = '0; cmd_num_evals = '0;
    m_raw = '0; m_xor = '0;

    vt[0] = mk(8'd1, {24'h0, 6'h2D}, 5'b00000, 17, 0, 6'h2D, 1'b0, 7'h00, 1'b0, 1);
    vt[1] = mk(8'd5, {6'h3A, 6'h2A, 6'h2B, 6'h2A, 6'h2A}, 5'b11011, 3, 0,
               6'h2A, 1'b1, 7'b1010001, 1'b0, 5);
    vt[2] = mk(8'd2, {18'h0, 6'h00, 6'h01}, 5'b00000, 4, 0, 6'h00, 1'b0, 7'h01, 1'b0, 2);
    vt[3] = mk(8'd0, {24'h0, 6'h15}, 5'b00001, 5, 0, 6'h15, 1'b1, 7'h00, 1'b0, 1);
    vt[4] = mk(8'd3, {12'h0, 6'h3F, 6'h00, 6'h3F}, 5'b00010, 2, 0, 6'h3F, 1'b0, 7'h7F, 1'b0, 3);
    vt[5] = mk(8'd4, {6'h00, 6'h00, 6'h00, 6'h03, 6'h03}, 5'b00000, 6, 0,
               6'h00, 1'b0, 7'h03, 1'b0, 4);
    vt[6] = mk(8'd1, 30'h0, 5'b00000, 1, 1, 6'h00, 1'b0, 7'h7F, 1'b1, 1);
    vt[7] = mk(8'd1, {24'h0, 6'h11}, 5'b00001, TO, 0, 6'h11, 1'b1, 7'h00, 1'b0, 1);
    vt[8] = mk(8'd2, 30'h0, 5'b00000, 1, 1, 6'h00, 1'b0, 7'h7F, 1'b1, 1);
    vt[9] = mk(8'd3, {12'h0, 6'h2A, 6'h15, 6'h2A}, 5'b00000, 1, 0, 6'h2A, 1'b0, 7'h3F, 1'b0, 3);

    repeat (3) tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1'b1));
    chk("rst_trigger", 64'(puf_trigger), 64'(1'b0));
    chk("rst_res_valid", 64'(res_valid), 64'(1'b0));
    chk("rst_res_response", 64'(res_response), 64'(0));
    chk("rst_res_xor", 64'(res_xor), 64'(1'b0));
    chk("rst_res_unstable", 64'(res_unstable), 64'(0));
    chk("rst_res_timeout", 64'(res_timeout), 64'(1'b0));
    chk("rst_challenge", puf_challenge, 64'(0));
    chk("rst_pdl", puf_pdl_config, 64'(0));
    reset = 1'b0;
    tick();

    foreach (vt[i]) begin
      string t;
      t = $sformatf("v%0d", i);
      m_raw = vt[i].raw; m_xor = vt[i].xr; m_lat = vt[i].lat; m_hang = vt[i].hang;
      m_idx = 0; trig_q.delete(); done_q.delete();
      e.resp = vt[i].e_resp; e.xr = vt[i].e_xor; e.unst = vt[i].e_unst; e.to = vt[i].e_to;
      e.chal = {$urandom, $urandom}; e.pdl = {$urandom, $urandom};
      sb.push_back(e);
      send(vt[i].n, e.chal, e.pdl, acc);
      wait_res(rv);
      check_result(t);
      chk({t, "_trig_cnt"}, 64'(trig_q.size()), 64'(vt[i].e_trig));
      if (trig_q.size() > 0) chk({t, "_first_trig"}, 64'(trig_q[0] - acc), 64'(1));
      for (int k = 1; k < trig_q.size() && k <= done_q.size(); k++)
        chk($sformatf("%s_gap%0d", t, k), 64'(trig_q[k] - done_q[k-1]), 64'(GAP + 1));
      if (vt[i].e_to) begin
        if (trig_q.size() > 0)
          chk({t, "_to_latency"}, 64'(rv - trig_q[trig_q.size()-1]), 64'(TO + 1));
      end else if (done_q.size() > 0) begin
        chk({t, "_res_latency"}, 64'(rv - done_q[done_q.size()-1]), 64'(1));
      end else begin
        chk({t, "_done_seen"}, 64'(0), 64'(1));
      end
      handshake(t);
      tick();
    end

    // Reset in the middle of WAIT; the late done must be ignored.
    m_lat = 8; m_hang = 0; m_idx = 0; m_raw = '1; m_xor = '1;
    trig_q.delete(); done_q.delete();
    send(8'd1, 64'hDEAD_BEEF_0000_0001, 64'h1, acc);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'(1'b1));
    chk("midrst_trigger", 64'(puf_trigger), 64'(1'b0));
    chk("midrst_res_valid", 64'(res_valid), 64'(1'b0));
    chk("midrst_challenge", puf_challenge, 64'(0));
    reset = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (res_valid !== 1'b0 || puf_trigger !== 1'b0 || cmd_ready !== 1'b1) bad = 1'b1;
    end
    chk("midrst_done_ignored_seen", 64'(done_q.size()), 64'(1));
    chk("midrst_done_ignored", 64'(bad), 64'(1'b0));

    // Backpressure, plus a command queued up while RESULT is held.
    m_lat = 3; m_hang = 0; m_idx = 0;
    m_raw = {6'h0, 6'h0, 6'h0, 6'h15, 6'h2A}; m_xor = 5'b00001;
    trig_q.delete(); done_q.delete();
    e.resp = 6'h2A; e.xr = 1'b1; e.unst = '0; e.to = 1'b0;
    e.chal = 64'h0123_4567_89AB_CDEF; e.pdl = 64'hFEDC_BA98_7654_3210;
    sb.push_back(e);
    send(8'd1, e.chal, e.pdl, acc);
    wait_res(rv);
    s_resp = res_response; s_unst = res_unstable; s_xor = res_xor;
    c2 = 64'h5555_AAAA_5555_AAAA;
    cmd_challenge = c2; cmd_pdl_config = 64'h77; cmd_num_evals = 8'd1; cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp%0d_cmd_ready", k), 64'(cmd_ready), 64'(1'b0));
      chk($sformatf("bp%0d_stable", k),
          64'({res_valid, res_response, res_xor, res_unstable}),
          64'({1'b1, s_resp, s_xor, s_unst}));
      tick();
    end
    check_result("bp");
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_ready_after_hs", 64'(cmd_ready), 64'(1'b1));
    chk("bp_no_early_trig", 64'(puf_trigger), 64'(1'b0));
    tick();
    cmd_valid = 1'b0;
    chk("bp_trig_after_accept", 64'(puf_trigger), 64'(1'b1));
    chk("bp_new_chal", puf_challenge, c2);
    e.resp = 6'h15; e.xr = 1'b0; e.unst = '0; e.to = 1'b0; e.chal = c2; e.pdl = 64'h77;
    sb.push_back(e);
    wait_res(rv);
    check_result("bp2");
    handshake("bp2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
